// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial W-bit adder time-sharing one full adder, valid/ready on both sides
module fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  assign sum = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         ovf,
  output logic         busy
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t st, st_nx;
  logic [W-1:0] ra, rb, rs;
  logic [CW-1:0] cnt;
  logic c, fs, fc, last;
  fa u_fa (.a(ra[0]), .b(rb[0]), .cin(c), .sum(fs), .cout(fc));
  always_comb begin
    last = cnt == CW'(W - 1);
    st_nx = st == IDLE ? (in_valid ? RUN : IDLE) :
            st == RUN  ? (last ? DONE : RUN) :
                         (out_ready ? IDLE : DONE);
  end
  assign in_ready = st == IDLE;
  assign out_valid = st == DONE;
  assign busy = st != IDLE;
  assign sum = rs;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st <= IDLE;
      ra <= '0;
      rb <= '0;
      rs <= '0;
      c <= 1'b0;
      cnt <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else begin
      st <= st_nx;
      if (st == IDLE && in_valid) begin
        ra <= a;
        rb <= b;
        rs <= '0;
        c <= cin;
        cnt <= '0;
        cout <= 1'b0;
        ovf <= 1'b0;
      end else if (st == RUN) begin
        ra <= ra >> 1;
        rb <= rb >> 1;
        rs <= {fs, rs[W-1:1]};
        c <= fc;
        cnt <= cnt + 1'b1;
        if (last) begin
          cout <= fc;
          ovf <= c ^ fc;
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: randomized self-checking bench for serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic clk = 0, rstn = 0, in_valid = 0, cin = 0, out_ready = 0;
  logic in_ready, out_valid, cout, ovf, busy;
  logic [W-1:0] a = '0, b = '0, sum;
  int checks = 0, errors = 0;
  serial_add_ctrl #(.W(W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );
  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(input logic [W-1:0] x, y, input logic ci);
    logic [W:0] full;
    logic v;
    full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
    v = (x[W-1] == y[W-1]) && (full[W-1] != x[W-1]);
    return {v, full};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [W-1:0] x, y, input logic ci, output int lat,
                        output logic [W-1:0] s, output logic co, ov);
    a = x;
    b = y;
    cin = ci;
    in_valid = 1;
    tick();
    in_valid = 0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    s = sum;
    co = cout;
    ov = ovf;
  endtask

  task automatic test_reset();
    rstn = 0;
    #3;
    checks++;
    if ({out_valid, busy, sum, cout, ovf, in_ready} !== {2'b00, {W{1'b0}}, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL reset: ov=%b busy=%b sum=%h cout=%b ovf=%b in_ready=%b expected 0 0 00 0 0 1",
               out_valid, busy, sum, cout, ovf, in_ready);
    end
    @(negedge clk);
    rstn = 1;
    tick();
  endtask

  task automatic test_directed();
    logic [W-1:0] va[4] = '{8'h5A, 8'hFF, 8'h7F, 8'h80};
    logic [W-1:0] vb[4] = '{8'h33, 8'h01, 8'h00, 8'h80};
    logic vc[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [W+1:0] ex[4] = '{{1'b1, 1'b0, 8'h8D}, {1'b0, 1'b1, 8'h00}, {1'b1, 1'b0, 8'h80}, {1'b1, 1'b1, 8'h00}};
    int lat;
    logic [W-1:0] s;
    logic co, ov;
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_in_ready: got %b expected 1", i, in_ready);
      end
      run_op(va[i], vb[i], vc[i], lat, s, co, ov);
      checks++;
      if (lat != W) begin
        errors++;
        $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, W);
      end
      checks++;
      if ({ov, co, s} !== ex[i]) begin
        errors++;
        $display("FAIL dir%0d_result: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
                 i, ov, co, s, ex[i][W+1], ex[i][W], ex[i][W-1:0]);
      end
      tick();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL dir%0d_release: got out_valid=%b in_ready=%b expected 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_random();
    int lat;
    logic [W-1:0] x, y, s;
    logic ci, co, ov;
    logic [W+1:0] ex;
    for (int i = 0; i < 20; i++) begin
      x = W'($urandom);
      y = W'($urandom);
      ci = 1'($urandom);
      out_ready = 1'($urandom);
      ex = model(x, y, ci);
      run_op(x, y, ci, lat, s, co, ov);
      checks++;
      if (lat != W || {ov, co, s} !== ex) begin
        errors++;
        $display("FAIL rand%0d: got lat=%0d ovf=%b cout=%b sum=%h expected lat=%0d ovf=%b cout=%b sum=%h (a=%h b=%h cin=%b)",
                 i, lat, ov, co, s, W, ex[W+1], ex[W], ex[W-1:0], x, y, ci);
      end
      if (!out_ready) begin
        tick();
        out_ready = 1;
      end
      tick();
      checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
        errors++;
        $display("FAIL rand%0d_release: got out_valid=%b in_ready=%b expected 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [W-1:0] x, y, s;
    logic ci, co, ov;
    logic [W+1:0] ex;
    x = W'($urandom);
    y = W'($urandom);
    ci = 1'($urandom);
    ex = model(x, y, ci);
    out_ready = 0;
    run_op(x, y, ci, lat, s, co, ov);
    checks++;
    if ({ov, co, s} !== ex) begin
      errors++;
      $display("FAIL bp_result: got ovf=%b cout=%b sum=%h expected ovf=%b cout=%b sum=%h",
               ov, co, s, ex[W+1], ex[W], ex[W-1:0]);
    end
    for (int i = 0; i < 5; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      in_valid = 1'($urandom);
      tick();
      checks++;
      if ({out_valid, in_ready, busy, ovf, cout, sum} !== {3'b101, ex}) begin
        errors++;
        $display("FAIL bp_hold%0d: got out_valid=%b in_ready=%b busy=%b ovf=%b cout=%b sum=%h expected 1 0 1 %b %b %h",
                 i, out_valid, in_ready, busy, ovf, cout, sum, ex[W+1], ex[W], ex[W-1:0]);
      end
    end
    in_valid = 0;
    out_ready = 1;
    tick();
    checks++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      errors++;
      $display("FAIL bp_release: got out_valid=%b in_ready=%b busy=%b expected 0 1 0", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [W+1:0] q[$];
    int acc[$];
    int n = 0, cyc = 0, got = 0;
    out_ready = 1;
    in_valid = 1;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    while ((n < 3 || got < 3) && cyc < 60) begin
      if (out_valid) begin
        checks++;
        if (q.size() == 0 || {ovf, cout, sum} !== q[0]) begin
          errors++;
          $display("FAIL b2b_result%0d: got ovf=%b cout=%b sum=%h expected %h", got, ovf, cout, sum,
                   q.size() ? q[0] : '0);
        end
        if (q.size()) void'(q.pop_front());
        got++;
      end
      if (in_ready && in_valid) begin
        q.push_back(model(a, b, cin));
        acc.push_back(cyc);
        n++;
      end
      tick();
      cyc++;
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      in_valid = n < 3;
    end
    in_valid = 0;
    checks++;
    if (n != 3 || got != 3) begin
      errors++;
      $display("FAIL b2b_timeout: accepts=%0d results=%0d expected 3 3", n, got);
    end
    for (int i = 1; i < acc.size(); i++) begin
      checks++;
      if (acc[i] - acc[i-1] != W + 2) begin
        errors++;
        $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, acc[i] - acc[i-1], W + 2);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lat;
    logic [W-1:0] s;
    logic co, ov;
    out_ready = 1;
    a = 8'hC7;
    b = 8'h9E;
    cin = 1;
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (3) tick();
    #2;
    rstn = 0;
    #1;
    checks++;
    if ({out_valid, busy, sum, cout, ovf, in_ready} !== {2'b00, {W{1'b0}}, 2'b00, 1'b1}) begin
      errors++;
      $display("FAIL midrun_reset: ov=%b busy=%b sum=%h cout=%b ovf=%b in_ready=%b expected 0 0 00 0 0 1",
               out_valid, busy, sum, cout, ovf, in_ready);
    end
    tick();
    @(negedge clk);
    rstn = 1;
    tick();
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL midrun_idle: got out_valid=%b busy=%b in_ready=%b expected 0 0 1", out_valid, busy, in_ready);
    end
    run_op(8'h01, 8'h01, 1'b0, lat, s, co, ov);
    checks++;
    if (lat != W || {ov, co, s} !== {2'b00, 8'h02}) begin
      errors++;
      $display("FAIL midrun_after: got lat=%0d ovf=%b cout=%b sum=%h expected lat=%0d 0 0 02", lat, ov, co, s, W);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that time-shares one instance of the team's one-bit full adder `fa` across all bits of a W-bit addition. It accepts operand pairs over a valid/ready handshake, feeds one bit pair per cycle into `fa` LSB-first, and keeps the running carry in a flip-flop. It returns the W-bit sum, carry-out and signed overflow over a second valid/ready handshake. It sits between a requester and a consumer wherever area matters more than throughput.

## Interface
- `W`, default 8: operand width; legal range W >= 2.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rstn`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand pair and carry-in are valid.
- `in_ready`  output  1  block can accept an operand pair; high only in IDLE.
- `a`  input  W  operand A, unsigned or two's complement.
- `b`  input  W  operand B.
- `cin`  input  1  carry-in.
- `out_valid`  output  1  result is valid.
- `out_ready`  input  1  consumer accepts the result.
- `sum`  output  W  a + b + cin, modulo 2^W.
- `cout`  output  1  carry out of bit W-1.
- `ovf`  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.
- `busy`  output  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN on `in_valid & in_ready`.
  - RUN -> DONE when the bit counter reaches W-1.
  - DONE -> IDLE on `out_valid & out_ready`.
- Internal registers: operand shift registers `ra` and `rb`, result shift register `rs`, carry flip-flop `c`, bit counter `cnt` of width $clog2(W).
- On accept:
  - `ra` <= `a`, `rb` <= `b`.
  - `c` <= `cin`, `cnt` <= 0.
  - `rs`, `cout` and `ovf` are cleared.
- Each RUN cycle:
  - `fa` inputs are `ra[0]`, `rb[0]` and `c`.
  - `ra` and `rb` shift right.
  - `rs` shifts right with `fa.sum` entering at bit W-1.
  - `c` <= `fa.cout`, `cnt` increments.
- On the last RUN cycle (`cnt` == W-1):
  - `cout` <= `fa.cout`.
  - `ovf` <= `c ^ fa.cout`, where `c` here is the carry into the MSB.
- `sum` is driven from `rs`. After W shifts bit 0 is in the correct position, so no re-alignment is needed.
- In DONE, `sum`, `cout` and `ovf` hold stable until the result is taken.
- `in_valid` is ignored outside IDLE. Operands are captured once, so `a`, `b` and `cin` may change freely after accept.
- No overlap: a new operation is not accepted until the previous result has been consumed.

## Timing
- Reset values (asserted asynchronously while `rstn` = 0):
  - `out_valid` = 0, `busy` = 0.
  - `sum` = 0, `cout` = 0, `ovf` = 0.
  - State = IDLE, `in_ready` = 1.
- Latency: `out_valid` rises exactly W cycles after the accepting edge.
- Result release:
  - If `out_ready` is already high when DONE is entered, the result is taken at the next edge; `out_valid` is then high for exactly 1 cycle.
  - `in_ready` rises the cycle after the output handshake.
- Maximum throughput: one operation per W+2 cycles.
- Backpressure: while `out_valid` & !`out_ready`, all outputs hold their values and `in_ready` stays 0.
- Reset mid-operation (RUN or DONE): the operation is abandoned and no result is produced. All outputs take their reset values immediately; the block is in IDLE on the first edge after `rstn` rises.
- `in_ready`, `out_valid` and `busy` are decoded from registered state only, with no combinational path from inputs.

## Test plan
- Basic add (W=8): `a`=8'h5A, `b`=8'h33, `cin`=0 -> `sum`=8'h8D, `cout`=0, `ovf`=1; `out_valid` rises 8 cycles after accept.
- Wrap-around: `a`=8'hFF, `b`=8'h01, `cin`=0 -> `sum`=8'h00, `cout`=1, `ovf`=0.
- Carry-in and overflow: `a`=8'h7F, `b`=8'h00, `cin`=1 -> `sum`=8'h80, `cout`=0, `ovf`=1. Also `a`=8'h80, `b`=8'h80, `cin`=0 -> `sum`=8'h00, `cout`=1, `ovf`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE while changing `a`, `b` and `in_valid` -> outputs stay stable, `in_ready`=0. Then `out_ready`=1 -> one-cycle handshake, `in_ready`=1 on the next cycle.
- Back-to-back: `in_valid`=1 and `out_ready`=1 held constant for 3 operations -> accepts are spaced exactly 10 cycles apart, and each result is correct.
- Reset mid-RUN: assert `rstn`=0 after 3 RUN cycles -> all outputs go to reset values immediately. After release, a new add of 8'h01+8'h01 -> `sum`=8'h02 with no residue from the aborted operation.
